// File: rtl/quant_fc_sequencer.sv
// Frame sequencer for the FC-layer quantizer: feeds accumulators one at a time through the
// quantizer, packs int8 results four per word and aborts the frame on a quantizer timeout.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | in_ready high, waiting for an accumulator
// QUANT | q_en high, waiting for q_done (timeout timer running)
// CLEAR | q_en low one cycle so the quantizer re-arms
// EMIT  | packed word presented, waiting for out_ready
// DONE  | frame_done pulse
module quant_fc_sequencer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             q_en,
    output logic [31:0]      q_data,
    input  logic             q_done,
    input  logic [7:0]       q_out,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_QUANT,
        S_CLEAR,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] elem_cnt;
    logic [1:0]       byte_idx;
    logic [31:0]      pack;
    logic [31:0]      q_data_r;
    logic [TMR_W-1:0] tmr;
    logic             err_r;

    logic last_elem;
    logic tmr_tc;

    assign last_elem = ((elem_cnt + LEN_W'(1)) == len_q);
    assign tmr_tc    = (tmr == '0);

    assign q_data      = q_data_r;
    assign out_data    = pack;
    assign err_timeout = err_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        q_en       = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_QUANT;
                end
            end
            S_QUANT: begin
                q_en = 1'b1;
                if (q_done) begin
                    state_nxt = S_CLEAR;
                end else if (tmr_tc) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_nxt = ((byte_idx == 2'd3) || last_elem) ? S_EMIT : S_FETCH;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = (elem_cnt == len_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q    <= '0;
            elem_cnt <= '0;
            byte_idx <= '0;
            pack     <= '0;
            q_data_r <= '0;
            tmr      <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        err_r    <= 1'b0;
                        elem_cnt <= '0;
                        byte_idx <= '0;
                        pack     <= '0;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        q_data_r <= in_data;
                        tmr      <= TMR_LOAD;
                    end
                end
                S_QUANT: begin
                    if (q_done) begin
                        pack[{byte_idx, 3'b000} +: 8] <= q_out;
                    end else if (tmr_tc) begin
                        // abort: the partial word never reaches the bus
                        err_r    <= 1'b1;
                        pack     <= '0;
                        byte_idx <= '0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_CLEAR: begin
                    elem_cnt <= elem_cnt + LEN_W'(1);
                    byte_idx <= byte_idx + 2'd1;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        pack     <= '0;
                        byte_idx <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quant_fc_sequencer.sv
// Directed bench for quant_fc_sequencer with a behavioural quantizer and a scoreboard of
// expected packed words.
module tb_quant_fc_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        q_en;
    logic [31:0] q_data;
    logic        q_done;
    logic [7:0]  q_out;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;

    quant_fc_sequencer #(.TIMEOUT_CYC(16), .LEN_W(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .q_en(q_en), .q_data(q_data), .q_done(q_done), .q_out(q_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] cur_word = '0;
    int cur_n = 0;
    int hs_cnt = 0, fd_cnt = 0, qen_cyc = 0, ir_cyc = 0;
    bit q_hang = 1'b0;
    bit viol = 1'b0;
    int qcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [7:0] q_model(input logic [31:0] x);
        longint p;
        p = (longint'($signed(x)) - 64'sd4) * 64'sh447EE7;
        return 8'(p >>> 24);
    endfunction

    task automatic flush_word();
        if (cur_n != 0) exp_q.push_back(cur_word);
        cur_word = '0;
        cur_n = 0;
    endtask

    task automatic add_elem(input logic [31:0] x);
        src_q.push_back(x);
        cur_word[cur_n*8 +: 8] = q_model(x);
        cur_n++;
        if (cur_n == 4) flush_word();
    endtask

    // quantizer: done one cycle, 3 cycles after q_en rises; q_en low clears it
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qcnt   <= 0;
            q_done <= 1'b0;
            q_out  <= '0;
        end else if (!q_en) begin
            qcnt   <= 0;
            q_done <= 1'b0;
        end else begin
            qcnt   <= qcnt + 1;
            q_done <= (qcnt == 2) && !q_hang;
            q_out  <= q_model(q_data);
        end
    end

    always @(negedge clk) begin
        in_valid = (src_q.size() != 0);
        in_data  = (src_q.size() != 0) ? src_q[0] : 32'h0;
    end

    always @(posedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready && src_q.size() != 0) void'(src_q.pop_front());
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) check("word_expected", 32'(exp_q.size()), 32'd1);
                else check("out_data", out_data, exp_q.pop_front());
            end
            if (frame_done) fd_cnt++;
            if (q_en) qen_cyc++;
            if (in_ready) ir_cyc++;
            if (q_en && (in_ready || out_valid)) viol = 1'b1;
            if (in_ready && out_valid) viol = 1'b1;
            if (!busy && (q_en || in_ready || out_valid || frame_done)) viol = 1'b1;
        end
    end

    task automatic start_frame(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = 16'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fd(input string tag, output int n);
        n = 0;
        while (!frame_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_done"}, frame_done, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_done_one_cycle"}, frame_done, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {in_ready, q_en, out_valid, busy, frame_done, err_timeout}, 6'b0);
        check({tag, "_q_data"}, q_data, 32'h0);
        check({tag, "_out_data"}, out_data, 32'h0);
    endtask

    initial begin
        int n, hs0, fd0, q0, ir0;
        bit stable;
        logic [31:0] hold;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;

        // four elements, one word
        hs0 = hs_cnt; fd0 = fd_cnt;
        add_elem(100); add_elem(4); add_elem(100); add_elem(4); flush_word();
        check("t1_exp_word", exp_q[0], 32'h00190019);
        start_frame(4);
        wait_fd("t1", n);
        check("t1_handshakes", 32'(hs_cnt - hs0), 32'd1);
        check("t1_fd_count", 32'(fd_cnt - fd0), 32'd1);

        // five elements, partial second word
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) add_elem(100);
        flush_word();
        start_frame(5);
        wait_fd("t2", n);
        check("t2_handshakes", 32'(hs_cnt - hs0), 32'd2);

        // empty frame
        hs0 = hs_cnt; q0 = qen_cyc; ir0 = ir_cyc;
        start_frame(0);
        wait_fd("t3", n);
        check("t3_done_latency", 32'(n), 32'd0);
        check("t3_no_q_en", 32'(qen_cyc - q0), 32'd0);
        check("t3_no_in_ready", 32'(ir_cyc - ir0), 32'd0);
        check("t3_no_out_valid", 32'(hs_cnt - hs0), 32'd0);

        // backpressure in EMIT
        out_ready = 1'b0;
        add_elem(100); add_elem(100); add_elem(100); add_elem(4); flush_word();
        start_frame(4);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        check("t4_out_valid", out_valid, 1'b1);
        hold = out_data;
        check("t4_out_data", hold, 32'h00191919);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(out_valid && out_data == hold && !in_ready && !q_en)) stable = 1'b0;
        end
        check("t4_stall_stable", stable, 1'b1);
        out_ready = 1'b1;
        wait_fd("t4", n);

        // quantizer timeout
        q_hang = 1'b1;
        hs0 = hs_cnt; fd0 = fd_cnt; q0 = qen_cyc;
        src_q.push_back(100);
        start_frame(2);
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check("t5_idle", busy, 1'b0);
        check("t5_err_timeout", err_timeout, 1'b1);
        check("t5_quant_cycles", 32'(qen_cyc - q0), 32'd16);
        check("t5_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("t5_no_out_valid", 32'(hs_cnt - hs0), 32'd0);
        q_hang = 1'b0;
        add_elem(0); add_elem(1000); flush_word();
        check("t5_exp_word", exp_q[0], 32'h00000AFE);
        start_frame(2);
        check("t5_err_cleared", err_timeout, 1'b0);
        wait_fd("t5b", n);

        // reset during QUANT of the second word
        for (int i = 0; i < 4; i++) add_elem(100);
        flush_word();
        for (int i = 0; i < 4; i++) src_q.push_back(32'd4);
        start_frame(8);
        n = 0;
        while (!(src_q.size() <= 3 && q_en) && n < 400) begin @(negedge clk); n++; end
        check("t6_in_quant", q_en, 1'b1);
        check("t6_first_word_sent", 32'(exp_q.size()), 32'd0);
        rstn = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        src_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        add_elem(100); add_elem(4); add_elem(100); flush_word();
        start_frame(3);
        wait_fd("t6b", n);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("protocol_ok", viol, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
